// File: rtl/tt_io_conditioner.sv
// Bidirectional pad conditioner: per-channel synchronizer, programmable glitch
// filter with edge pulses, registered push-pull/open-drain output path, glitch counter.
module tt_io_conditioner #(
    parameter int                    CHANNELS    = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FILT_BITS   = 3,
    parameter logic [CHANNELS-1:0]   RESET_VAL   = {CHANNELS{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [CHANNELS-1:0]   pad_in,
    output logic [CHANNELS-1:0]   pad_out,
    output logic [CHANNELS-1:0]   pad_oe,
    input  logic [CHANNELS-1:0]   core_out,
    input  logic [CHANNELS-1:0]   core_oe,
    input  logic [CHANNELS-1:0]   od_mode,
    input  logic [FILT_BITS-1:0]  filt_len,
    output logic [CHANNELS-1:0]   core_in,
    output logic [CHANNELS-1:0]   rise,
    output logic [CHANNELS-1:0]   fall,
    input  logic                  glitch_clr,
    output logic [7:0]            glitch_cnt
);

    logic [CHANNELS-1:0]  sync_q [SYNC_STAGES];
    logic [FILT_BITS-1:0] cnt_q  [CHANNELS];
    logic [CHANNELS-1:0]  s;
    logic [CHANNELS-1:0]  reject;
    logic                 any_reject;

    assign s = sync_q[SYNC_STAGES-1];

    // The synchronizer free-runs so the chain is already settled when ena rises.
    // NOTE: this small flop array is reset explicitly; it is real state, not a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
        end else begin
            // NOTE: non-blocking so every stage samples the previous stage's old value.
            sync_q[0] <= pad_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // A glitch is rejected when the input falls back before qualification.
    // NOTE: defaults first so no path through always_comb leaves a latch.
    always_comb begin
        reject = '0;
        for (int i = 0; i < CHANNELS; i++)
            reject[i] = (s[i] == core_in[i]) && (cnt_q[i] != '0);
        any_reject = ena && (|reject);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_in <= RESET_VAL;
            rise    <= '0;
            fall    <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
        end else if (!ena) begin
            rise <= '0;
            fall <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                rise[i] <= 1'b0;
                fall[i] <= 1'b0;
                if (s[i] == core_in[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] >= filt_len) begin
                    // >= lets a lowered filt_len accept at once; cnt never exceeds filt_len.
                    core_in[i] <= s[i];
                    cnt_q[i]   <= '0;
                    rise[i]    <= s[i];
                    fall[i]    <= ~s[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_cnt <= '0;
        end else if (ena) begin
            if (glitch_clr)
                glitch_cnt <= '0;
            else if (any_reject && (glitch_cnt != 8'hFF))
                glitch_cnt <= glitch_cnt + 8'd1;
        end
    end

    // Open-drain channels only ever pull low: drive 0 and enable when core_out is 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out <= '0;
            pad_oe  <= '0;
        end else if (!ena) begin
            pad_out <= '0;
            pad_oe  <= '0;
        end else begin
            pad_out <= core_out & ~od_mode;
            pad_oe  <= core_oe & ~(od_mode & core_out);
        end
    end

endmodule

// File: tb/tb_tt_io_conditioner.sv
// Directed self-checking bench for tt_io_conditioner with hand-computed expectations.
module tb_tt_io_conditioner;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] pad_in;
    logic [7:0] pad_out;
    logic [7:0] pad_oe;
    logic [7:0] core_out;
    logic [7:0] core_oe;
    logic [7:0] od_mode;
    logic [2:0] filt_len;
    logic [7:0] core_in;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       glitch_clr;
    logic [7:0] glitch_cnt;

    int checks   = 0;
    int failures = 0;

    tt_io_conditioner dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .pad_in     (pad_in),
        .pad_out    (pad_out),
        .pad_oe     (pad_oe),
        .core_out   (core_out),
        .core_oe    (core_oe),
        .od_mode    (od_mode),
        .filt_len   (filt_len),
        .core_in    (core_in),
        .rise       (rise),
        .fall       (fall),
        .glitch_clr (glitch_clr),
        .glitch_cnt (glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        ena        = 1'b1;
        pad_in     = 8'hFF;
        core_out   = 8'h00;
        core_oe    = 8'h00;
        od_mode    = 8'h00;
        filt_len   = 3'd3;
        glitch_clr = 1'b0;

        // Reset state and idle-high hold
        step(2);
        check("rst_core_in", core_in, 8'hFF);
        check("rst_rise", rise, 8'h00);
        check("rst_fall", fall, 8'h00);
        check("rst_pad_oe", pad_oe, 8'h00);
        check("rst_pad_out", pad_out, 8'h00);
        check("rst_glitch", glitch_cnt, 8'h00);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            check("idle_core_in", core_in, 8'hFF);
            check("idle_pad_oe", pad_oe, 8'h00);
            check("idle_edges", rise | fall, 8'h00);
            check("idle_glitch", glitch_cnt, 8'h00);
        end

        // filt_len=0: fall at T+3 for one cycle
        filt_len  = 3'd0;
        pad_in[0] = 1'b0;
        step(2);
        check("f0_core_in_t2", core_in, 8'hFF);
        check("f0_fall_t2", fall, 8'h00);
        step(1);
        check("f0_core_in_t3", core_in, 8'hFE);
        check("f0_fall_t3", fall, 8'h01);
        step(1);
        check("f0_fall_t4", fall, 8'h00);
        pad_in[0] = 1'b1;
        step(3);
        check("f0_rise_t3", rise, 8'h01);
        check("f0_restore", core_in, 8'hFF);
        check("f0_no_glitch", glitch_cnt, 8'h00);

        // filt_len=3: 2-cycle low rejected
        filt_len  = 3'd3;
        pad_in[2] = 1'b0;
        step(2);
        pad_in[2] = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(1);
            check("short_core_in", core_in, 8'hFF);
            check("short_fall", fall, 8'h00);
        end
        check("short_glitch", glitch_cnt, 8'h01);

        // filt_len=3: 4-cycle low accepted, fall at T+6, rise at T+10
        pad_in[2] = 1'b0;
        step(4);
        pad_in[2] = 1'b1;
        step(1);
        check("long_fall_t5", fall, 8'h00);
        check("long_core_t5", core_in, 8'hFF);
        step(1);
        check("long_fall_t6", fall, 8'h04);
        check("long_core_t6", core_in, 8'hFB);
        step(1);
        check("long_fall_t7", fall, 8'h00);
        step(2);
        check("long_rise_t9", rise, 8'h00);
        check("long_core_t9", core_in, 8'hFB);
        step(1);
        check("long_rise_t10", rise, 8'h04);
        check("long_core_t10", core_in, 8'hFF);
        step(1);
        check("long_rise_t11", rise, 8'h00);
        check("long_glitch", glitch_cnt, 8'h01);

        // Output path: open-drain on channel 1, then push-pull
        core_oe  = 8'hFF;
        od_mode  = 8'h02;
        core_out = 8'h00;
        step(1);
        check("od_lo_oe", pad_oe, 8'hFF);
        check("od_lo_out", pad_out, 8'h00);
        core_out = 8'h02;
        #1;
        check("od_hi_oe_delay", pad_oe, 8'hFF);
        step(1);
        check("od_hi_oe", pad_oe, 8'hFD);
        check("od_hi_out", pad_out, 8'h00);
        od_mode = 8'h00;
        step(1);
        check("pp_hi_oe", pad_oe, 8'hFF);
        check("pp_hi_out", pad_out, 8'h02);
        core_out = 8'h00;
        step(1);
        check("pp_lo_oe", pad_oe, 8'hFF);
        check("pp_lo_out", pad_out, 8'h00);

        // Glitch counter: clear, 100 then 300 single-channel glitches
        filt_len   = 3'd1;
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        check("gc_clear", glitch_cnt, 8'h00);
        for (int g = 0; g < 300; g++) begin
            pad_in[3] = 1'b0;
            step(1);
            pad_in[3] = 1'b1;
            step(3);
            if (g == 99) begin
                step(2);
                check("gc_100", glitch_cnt, 8'd100);
            end
        end
        step(4);
        check("gc_sat", glitch_cnt, 8'hFF);
        check("gc_core_in", core_in, 8'hFF);

        // Simultaneous rejections on two channels count once
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        pad_in[4:3] = 2'b00;
        step(1);
        pad_in[4:3] = 2'b11;
        step(5);
        check("gc_simul", glitch_cnt, 8'h01);

        // Clear in the same cycle as a rejection (rejection lands on the 4th edge)
        pad_in[3] = 1'b0;
        step(1);
        pad_in[3] = 1'b1;
        step(2);
        glitch_clr = 1'b1;
        step(1);
        glitch_clr = 1'b0;
        check("gc_clr_wins", glitch_cnt, 8'h00);
        step(3);
        check("gc_clr_hold", glitch_cnt, 8'h00);

        // ena=0 during a qualifying low pulse
        filt_len = 3'd3;
        core_out = 8'hFF;
        step(1);
        check("ena_pre_oe", pad_oe, 8'hFF);
        check("ena_pre_out", pad_out, 8'hFF);
        ena       = 1'b0;
        pad_in[5] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            step(1);
            check("ena0_fall", fall, 8'h00);
            check("ena0_core_in", core_in, 8'hFF);
            check("ena0_pad_oe", pad_oe, 8'h00);
            check("ena0_pad_out", pad_out, 8'h00);
        end
        pad_in[5] = 1'b1;
        step(4);
        ena = 1'b1;
        step(6);
        check("ena1_core_in", core_in, 8'hFF);
        check("ena1_fall", fall, 8'h00);
        check("ena1_glitch", glitch_cnt, 8'h00);
        check("ena1_pad_oe", pad_oe, 8'hFF);

        // Reset mid filter count, then full requalification latency
        core_out  = 8'h00;
        pad_in[6] = 1'b0;
        step(4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_core_in", core_in, 8'hFF);
        check("mid_rst_pad_oe", pad_oe, 8'h00);
        check("mid_rst_fall", fall, 8'h00);
        #2;
        rst_n = 1'b1;
        step(5);
        check("post_rst_t5", core_in, 8'hFF);
        check("post_rst_fall_t5", fall, 8'h00);
        step(1);
        check("post_rst_t6", core_in, 8'hBF);
        check("post_rst_fall_t6", fall, 8'h40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
